// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : mem_arb_pkg
//  Purpose   : Shared defaults, port-select encoding and width helper for the
//              exmem2 dual-port memory arbiter.
//  Revision  : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 16;
    localparam int ADDR_W_DEF  = 8;

    // Which exmem2 port served a read, remembered until the data returns.
    typedef enum logic {
        PORT1 = 1'b0,
        PORT2 = 1'b1
    } port_sel_e;

    // ceil(log2(n)), never less than 1 so a pointer always has a bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module    : rr_pick
//  Purpose   : Round-robin picker. Scans ptr, ptr+1, ... modulo N and returns
//              the first requester whose req and mask bits are both set.
//  Revision  : 1.0  initial release
// ============================================================================
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N  = NUM_REQ_DEF,
    parameter int PW = clog2_min1(N)
)(
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    input  logic [N-1:0]  mask_i,
    output logic [N-1:0]  onehot_o,
    output logic [PW-1:0] idx_o,
    output logic          found_o
);

    // Priority scan starting at the pointer, first hit wins.
    always_comb begin
        int j;
        j        = 0;
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!found_o && req_i[j] && mask_i[j]) begin
                found_o     = 1'b1;
                idx_o       = PW'(j);
                onehot_o[j] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : mem_port_arbiter
//  Purpose   : Shares the dual-port exmem2 game memory among NUM_REQ
//              requesters. Up to two round-robin winners per cycle: winner A
//              on port 1, winner B on port 2. Reads return one cycle later.
//  Revision  : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ-1:0]          req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [NUM_REQ-1:0]          rvalid_o,
    output logic [NUM_REQ*DATA_W-1:0]   rdata_o,
    output logic [ADDR_W-1:0]           mem_addr1_o,
    output logic [ADDR_W-1:0]           mem_addr2_o,
    output logic [DATA_W-1:0]           mem_din1_o,
    output logic [DATA_W-1:0]           mem_din2_o,
    output logic                        mem_we1_o,
    output logic                        mem_we2_o,
    input  logic [DATA_W-1:0]           mem_dout1_i,
    input  logic [DATA_W-1:0]           mem_dout2_i
);

    localparam int PW = clog2_min1(NUM_REQ);

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    port_sel_e          rsel_q [NUM_REQ];
    port_sel_e          rsel_d [NUM_REQ];

    logic [NUM_REQ-1:0] all_ones;
    logic [NUM_REQ-1:0] onehot_a, onehot_b, mask_b;
    logic [PW-1:0]      idx_a, idx_b, start_b;
    logic               found_a, found_b, b_ok;
    logic [ADDR_W-1:0]  addr_a, addr_b;
    logic [DATA_W-1:0]  wdata_a, wdata_b;

    // Wrap-around increment of a requester index.
    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
        if (int'(v) == NUM_REQ - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    assign all_ones = '1;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick_a (
        .req_i    (req_i),
        .ptr_i    (ptr_q),
        .mask_i   (all_ones),
        .onehot_o (onehot_a),
        .idx_o    (idx_a),
        .found_o  (found_a)
    );

    // B candidate is simply the next requester after A in the scan; an
    // address match with A does not skip ahead, it cancels B for this cycle.
    assign start_b = wrap_inc(idx_a);
    assign mask_b  = ~onehot_a;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick_b (
        .req_i    (req_i),
        .ptr_i    (start_b),
        .mask_i   (mask_b),
        .onehot_o (onehot_b),
        .idx_o    (idx_b),
        .found_o  (found_b)
    );

    assign addr_a  = req_addr_i[int'(idx_a)*ADDR_W +: ADDR_W];
    assign addr_b  = req_addr_i[int'(idx_b)*ADDR_W +: ADDR_W];
    assign wdata_a = req_wdata_i[int'(idx_a)*DATA_W +: DATA_W];
    assign wdata_b = req_wdata_i[int'(idx_b)*DATA_W +: DATA_W];
    assign b_ok    = found_a && found_b && (addr_b != addr_a);

    // Port muxes and grants; everything held quiet while reset is low.
    always_comb begin
        gnt_o       = '0;
        mem_addr1_o = '0;
        mem_din1_o  = '0;
        mem_we1_o   = 1'b0;
        mem_addr2_o = '0;
        mem_din2_o  = '0;
        mem_we2_o   = 1'b0;
        if (reset) begin
            if (found_a) begin
                gnt_o       = gnt_o | onehot_a;
                mem_addr1_o = addr_a;
                mem_din1_o  = wdata_a;
                mem_we1_o   = req_we_i[idx_a];
            end
            if (b_ok) begin
                gnt_o       = gnt_o | onehot_b;
                mem_addr2_o = addr_b;
                mem_din2_o  = wdata_b;
                mem_we2_o   = req_we_i[idx_b];
            end
        end
    end

    // Next pointer, read-return flags and the port each read came from.
    always_comb begin
        ptr_d = ptr_q;
        if (b_ok) begin
            ptr_d = wrap_inc(idx_b);
        end else if (found_a) begin
            ptr_d = wrap_inc(idx_a);
        end
        rvalid_d = gnt_o & ~req_we_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsel_d[i] = (b_ok && onehot_b[i]) ? PORT2 : PORT1;
        end
    end

    // State registers; a low reset drops any read still in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsel_q[i] <= PORT1;
            end
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsel_q[i] <= rsel_d[i];
            end
        end
    end

    // Masking with reset keeps a read granted just before reset from
    // surfacing while reset is held.
    assign rvalid_o = rvalid_q & {NUM_REQ{reset}};

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rdata
            assign rdata_o[gi*DATA_W +: DATA_W] =
                !rvalid_o[gi]         ? '0 :
                (rsel_q[gi] == PORT2) ? mem_dout2_i : mem_dout1_i;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module    : tb_mem_port_arbiter
//  Purpose   : Self-checking bench for mem_port_arbiter with a behavioural
//              arbitration/memory model and directed scenarios.
//  Revision  : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int AW = 8;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req, we;
    logic [AW-1:0]   addr  [N];
    logic [DW-1:0]   wdata [N];
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt, rvalid;
    logic [N*DW-1:0] rdata;
    logic [AW-1:0]   maddr1, maddr2;
    logic [DW-1:0]   mdin1, mdin2, mdout1, mdout2;
    logic            mwe1, mwe2;

    int checks = 0;
    int errors = 0;

    assign req_addr  = {addr[3], addr[2], addr[1], addr[0]};
    assign req_wdata = {wdata[3], wdata[2], wdata[1], wdata[0]};

    mem_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_i       (req),
        .req_we_i    (we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .mem_addr1_o (maddr1),
        .mem_addr2_o (maddr2),
        .mem_din1_o  (mdin1),
        .mem_din2_o  (mdin2),
        .mem_we1_o   (mwe1),
        .mem_we2_o   (mwe2),
        .mem_dout1_i (mdout1),
        .mem_dout2_i (mdout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for exmem2: dual port, synchronous read.
    logic [DW-1:0] bmem [256];
    always @(posedge clk) begin
        if (mwe1) bmem[maddr1] <= mdin1;
        if (mwe2) bmem[maddr2] <= mdin2;
        mdout1 <= bmem[maddr1];
        mdout2 <= bmem[maddr2];
    end

    // ---------------- behavioural model ----------------
    int            m_ptr;
    logic [DW-1:0] m_mem [256];
    logic [N-1:0]  m_rv;
    logic [DW-1:0] m_rd [N];

    // Round-robin winners from the rules: A first set req from ptr,
    // B the next set req after A unless it shares A's address.
    function automatic void pick(input logic [N-1:0] r, input int p,
                                 output int a, output int b);
        bit seen_b;
        a = -1;
        b = -1;
        seen_b = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (r[j]) begin
                if (a < 0) a = j;
                else if (!seen_b) begin
                    seen_b = 1;
                    if (addr[j] != addr[a]) b = j;
                end
            end
        end
    endfunction

    always @(posedge clk) begin
        int a, b;
        if (!reset) begin
            m_ptr = 0;
            m_rv  = '0;
        end else begin
            pick(req, m_ptr, a, b);
            m_rv = '0;
            if (a >= 0 && !we[a]) begin m_rv[a] = 1'b1; m_rd[a] = m_mem[addr[a]]; end
            if (b >= 0 && !we[b]) begin m_rv[b] = 1'b1; m_rd[b] = m_mem[addr[b]]; end
            if (a >= 0 && we[a]) m_mem[addr[a]] = wdata[a];
            if (b >= 0 && we[b]) m_mem[addr[b]] = wdata[b];
            if (b >= 0)      m_ptr = (b + 1) % N;
            else if (a >= 0) m_ptr = (a + 1) % N;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        int a, b;
        logic [N-1:0]    eg;
        logic [AW-1:0]   ea1, ea2;
        logic [DW-1:0]   ed1, ed2;
        logic            ew1, ew2;
        logic [N*DW-1:0] erd;
        eg = '0; ea1 = '0; ea2 = '0; ed1 = '0; ed2 = '0; ew1 = 0; ew2 = 0; erd = '0;
        a = -1; b = -1;
        if (reset) pick(req, m_ptr, a, b);
        if (a >= 0) begin eg[a] = 1'b1; ea1 = addr[a]; ed1 = wdata[a]; ew1 = we[a]; end
        if (b >= 0) begin eg[b] = 1'b1; ea2 = addr[b]; ed2 = wdata[b]; ew2 = we[b]; end
        for (int i = 0; i < N; i++)
            if (reset && m_rv[i]) erd[i*DW +: DW] = m_rd[i];
        chk("m_gnt",    64'(gnt),    64'(eg));
        chk("m_port1",  {mwe1, maddr1, mdin1}, {ew1, ea1, ed1});
        chk("m_port2",  {mwe2, maddr2, mdin2}, {ew2, ea2, ed2});
        chk("m_rvalid", 64'(rvalid), 64'(reset ? m_rv : 4'b0));
        chk("m_rdata",  rdata,       erd);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] glog [4];
        for (int i = 0; i < 256; i++) begin
            bmem[i]  = 16'h1000 + 16'(i);
            m_mem[i] = 16'h1000 + 16'(i);
        end
        for (int i = 0; i < N; i++) begin
            addr[i]  = 8'(10 + i);
            wdata[i] = '0;
        end
        reset = 1'b0;
        req   = 4'b1111;
        we    = 4'b0000;

        // 1: reset holds everything quiet, then ptr starts at 0
        repeat (3) begin
            @(negedge clk);
            chk("t1_gnt",    64'(gnt), 64'h0);
            chk("t1_we",     64'({mwe1, mwe2}), 64'h0);
            chk("t1_rvalid", 64'(rvalid), 64'h0);
        end
        step();
        reset = 1'b1;
        @(negedge clk); chk("t1_first_gnt", 64'(gnt), 64'b0011);
        step(); req[1:0] = 2'b00;
        @(negedge clk); chk("t1_second_gnt", 64'(gnt), 64'b1100);
        step(); req = '0;
        @(negedge clk); chk("t1_rvalid_ret", 64'(rvalid), 64'b1100);

        // 2: write then read back on requester 0
        step();
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'd5; wdata[0] = 16'h0045;
        @(negedge clk);
        chk("t2_gnt", 64'(gnt), 64'b0001);
        chk("t2_port1", {mwe1, maddr1}, {1'b1, 8'd5});
        step(); we[0] = 1'b0;
        @(negedge clk); chk("t2_rd_gnt", 64'(gnt), 64'b0001);
        step(); req = '0;
        @(negedge clk);
        chk("t2_rvalid", 64'(rvalid), 64'b0001);
        chk("t2_rdata0", 64'(rdata[15:0]), 64'h0045);

        // 3: two writes granted together, then read back
        step();
        reset = 1'b0;
        req = 4'b0110; we = 4'b0110;
        addr[1] = 8'd1; wdata[1] = 16'd69;
        addr[2] = 8'd3; wdata[2] = 16'd21;
        step(); reset = 1'b1;
        @(negedge clk);
        chk("t3_gnt", 64'(gnt), 64'b0110);
        chk("t3_addrs", {maddr1, maddr2}, {8'd1, 8'd3});
        step(); we = '0;
        @(negedge clk); chk("t3_rd_gnt", 64'(gnt), 64'b0110);
        step(); req = '0;
        @(negedge clk);
        chk("t3_rvalid", 64'(rvalid), 64'b0110);
        chk("t3_rdata1", 64'(rdata[31:16]), 64'd69);
        chk("t3_rdata2", 64'(rdata[47:32]), 64'd21);

        // 4: same-address pair serialises
        step();
        reset = 1'b0;
        req = 4'b1001; we = '0; addr[0] = 8'd7; addr[3] = 8'd7;
        step(); reset = 1'b1;
        @(negedge clk); chk("t4_gnt1", 64'(gnt), 64'b0001);
        step(); req[0] = 1'b0;
        @(negedge clk);
        chk("t4_gnt2", 64'(gnt), 64'b1000);
        chk("t4_rv1",  64'(rvalid), 64'b0001);
        step(); req = '0;
        @(negedge clk);
        chk("t4_rv2", 64'(rvalid), 64'b1000);
        chk("t4_rdata3", 64'(rdata[63:48]), 64'h1007);

        // 5: all four hold reads back-to-back with fresh addresses
        step();
        reset = 1'b0;
        req = 4'b1111; we = '0;
        for (int i = 0; i < N; i++) addr[i] = 8'(20 + i);
        step(); reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); glog[c] = gnt;
            step();
            for (int i = 0; i < N; i++) if (glog[c][i]) addr[i] = addr[i] + 8'd8;
        end
        req = '0;
        chk("t5_seq", {glog[0], glog[1], glog[2], glog[3]},
            {4'b0011, 4'b1100, 4'b0011, 4'b1100});

        // 6: read in flight when reset drops is discarded
        step();
        reset = 1'b0;
        step(); reset = 1'b1;
        req = 4'b0100; addr[2] = 8'd40;
        @(negedge clk); chk("t6_gnt", 64'(gnt), 64'b0100);
        step();
        reset = 1'b0;
        req = 4'b1010; addr[1] = 8'd41; addr[3] = 8'd43;
        @(negedge clk);
        chk("t6_rv_in_reset", 64'(rvalid), 64'h0);
        chk("t6_gnt_in_reset", 64'(gnt), 64'h0);
        step(); reset = 1'b1;
        @(negedge clk);
        chk("t6_rv_after", 64'(rvalid), 64'h0);
        chk("t6_gnt_after", 64'(gnt), 64'b1010);
        chk("t6_port1_addr", 64'(maddr1), 64'd41);
        step(); req = '0;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
